// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the multi-digit BCD-to-binary converter.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, COMP, DONE} bcd_state_t;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

   // Smallest result width w with 2**w >= 10**digits.
   function automatic int min_bin_width(input int digits);
      longint p;
      int     w;
      p = 1;
      for (int i = 0; i < digits; i++) p = p * 10;
      w = 0;
      for (int i = 0; i < 62; i++)
         if ((longint'(1) << i) < p) w = i + 1;
      return w;
   endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit correction step of reverse double-dabble: subtract 3 from any digit >= 8.
module bcd_digit_corr (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd8) ? digit_i - 4'd3 : digit_i;

endmodule

// File: rtl/bcd_to_bin_n.sv
// Iterative DIGITS-digit BCD-to-binary converter (shift right / correct), BIN_W cycles per conversion.
module bcd_to_bin_n
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  ready,
   output logic                  done_tick,
   output logic                  err,
   output logic [BIN_W-1:0]      binary_value
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $fatal(1, "bcd_to_bin_n: DIGITS must be in 1..8");
   end
   if (BIN_W < min_bin_width(DIGITS)) begin : g_bad_width
      $fatal(1, "bcd_to_bin_n: BIN_W too small to hold 10**DIGITS-1");
   end

   bcd_state_t        state_q;
   logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_sh;
   logic [BIN_W-1:0]  bin_q, bin_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [BIN_W-1:0]  result_q;
   logic              err_q, done_q;
   logic              bad_digit;

   // One right shift of the whole {digits, result} chain, then per-digit correction.
   assign {bcd_sh, bin_d} = {bcd_q, bin_q} >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      bcd_digit_corr u_corr (
         .digit_i (bcd_sh[4*g +: 4]),
         .digit_o (bcd_d[4*g +: 4])
      );
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int k = 0; k < DIGITS; k++)
         if (bcd_in[4*k +: 4] > BCD_MAX_DIGIT) bad_digit = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         bcd_q    <= '0;
         bin_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (bad_digit) begin
                     result_q <= '0;
                     err_q    <= 1'b1;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     bcd_q   <= bcd_in;
                     bin_q   <= '0;
                     cnt_q   <= CNT_W'(BIN_W);
                     state_q <= COMP;
                  end
               end
            end
            COMP: begin
               bcd_q <= bcd_d;
               bin_q <= bin_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  result_q <= bin_d;
                  err_q    <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready        = (state_q == IDLE);
   assign done_tick    = done_q;
   assign err          = err_q;
   assign binary_value = result_q;

endmodule

// File: tb/tb_bcd_to_bin_n.sv
// Self-checking bench for bcd_to_bin_n: default 4-digit instance plus a 2-digit/7-bit instance.
module tb_bcd_to_bin_n;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;
   localparam int LAT    = BIN_W + 1;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [4*DIGITS-1:0] bcd_in;
   logic                ready, done_tick, err;
   logic [BIN_W-1:0]    binary_value;

   logic                start2;
   logic [7:0]          bcd2;
   logic                ready2, done2, err2;
   logic [6:0]          bv2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bcd_to_bin_n #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dut (
      .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
      .ready(ready), .done_tick(done_tick), .err(err), .binary_value(binary_value)
   );

   bcd_to_bin_n #(.DIGITS(2), .BIN_W(7)) u_dut2 (
      .clk(clk), .reset(reset), .start(start2), .bcd_in(bcd2),
      .ready(ready2), .done_tick(done2), .err(err2), .binary_value(bv2)
   );

   // Reference: decimal value of the digit string and whether any digit is non-decimal.
   function automatic void model(input logic [15:0] b, input int nd, output int val, output bit bad);
      int p;
      logic [3:0] d;
      val = 0; bad = 1'b0; p = 1;
      for (int k = 0; k < nd; k++) begin
         d = b[4*k +: 4];
         if (d > 9) bad = 1'b1;
         val = val + int'(d) * p;
         p = p * 10;
      end
      if (bad) val = 0;
   endfunction

   function automatic logic [15:0] rand_bcd(input bit allow_bad);
      logic [15:0] b;
      for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
      if (allow_bad && ($urandom_range(0, 3) == 0))
         b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      return b;
   endfunction

   // Drives one request on the default DUT; lat = cycle index of done_tick, 0 on timeout.
   task automatic convert(input logic [15:0] b, output int lat, output logic [BIN_W-1:0] bv,
                          output logic e, output bit one_pulse);
      int w;
      lat = 0; bv = '0; e = 1'b0; one_pulse = 1'b0;
      w = 0;
      @(negedge clk);
      while (!ready && w < 40) begin @(negedge clk); w++; end
      start = 1'b1; bcd_in = b;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bcd_in = 16'($urandom);
         if (done_tick) begin
            lat = c; bv = binary_value; e = err;
            break;
         end
      end
      @(negedge clk);
      one_pulse = !done_tick;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; bcd_in = '0; start2 = 1'b0; bcd2 = '0;
      repeat (2) @(negedge clk);
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
      tests++; if (done_tick !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done_tick); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
      tests++; if (binary_value !== '0) begin fails++; $display("FAIL reset_bv got=%0d exp=0", binary_value); end
      reset = 1'b0;
   endtask

   task automatic test_vectors();
      logic [15:0] vec [6] = '{16'h9999, 16'h1234, 16'h0000, 16'h12A4, 16'h0042, 16'hF000};
      int lat, ev, el; bit eb, op;
      logic [BIN_W-1:0] bv; logic e;
      foreach (vec[i]) begin
         model(vec[i], 4, ev, eb);
         el = eb ? 1 : LAT;
         convert(vec[i], lat, bv, e, op);
         tests++; if (lat != el) begin fails++; $display("FAIL vec_latency bcd=%h got=%0d exp=%0d", vec[i], lat, el); end
         tests++; if (bv !== BIN_W'(ev)) begin fails++; $display("FAIL vec_value bcd=%h got=%0d exp=%0d", vec[i], bv, ev); end
         tests++; if (e !== eb) begin fails++; $display("FAIL vec_err bcd=%h got=%b exp=%b", vec[i], e, eb); end
         tests++; if (!op) begin fails++; $display("FAIL vec_pulse_width bcd=%h got=wide exp=one", vec[i]); end
      end
   endtask

   task automatic test_hold();
      int lat, ev; bit eb, op, extra;
      logic [BIN_W-1:0] bv; logic e;
      convert(16'h0731, lat, bv, e, op);
      model(16'h0731, 4, ev, eb);
      extra = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bcd_in = 16'($urandom);
         if (done_tick) extra = 1'b1;
      end
      tests++; if (binary_value !== BIN_W'(ev)) begin fails++; $display("FAIL hold_value got=%0d exp=%0d", binary_value, ev); end
      tests++; if (err !== 1'b0 || extra) begin fails++; $display("FAIL hold_quiet got err=%b tick=%b exp 0/0", err, extra); end
   endtask

   task automatic test_random();
      logic [15:0] b;
      int lat, ev, el; bit eb, op;
      logic [BIN_W-1:0] bv; logic e;
      for (int n = 0; n < 25; n++) begin
         b = rand_bcd(1'b1);
         model(b, 4, ev, eb);
         el = eb ? 1 : LAT;
         convert(b, lat, bv, e, op);
         tests++;
         if (lat != el || bv !== BIN_W'(ev) || e !== eb || !op) begin
            fails++;
            $display("FAIL rand bcd=%h got lat=%0d val=%0d err=%b one=%b exp lat=%0d val=%0d err=%b",
                     b, lat, bv, e, op, el, ev, eb);
         end
      end
   endtask

   task automatic test_back_to_back();
      int q [$];
      int ev, dones, last, rdy_cnt;
      bit eb;
      dones = 0; last = -1; rdy_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < 200 && dones < 5; c++) begin
         if (c > 0) @(negedge clk);
         if (done_tick) begin
            tests++;
            if (q.size() == 0) begin
               fails++; $display("FAIL b2b_unexpected_done cycle=%0d got=%0d exp=none", c, binary_value);
            end else begin
               ev = q.pop_front();
               if (binary_value !== BIN_W'(ev)) begin
                  fails++; $display("FAIL b2b_value got=%0d exp=%0d", binary_value, ev);
               end
            end
            if (last >= 0) begin
               tests++;
               if (c - last != BIN_W + 2 || rdy_cnt != 1) begin
                  fails++; $display("FAIL b2b_spacing got=%0d ready_cycles=%0d exp=%0d/1", c - last, rdy_cnt, BIN_W + 2);
               end
            end
            last = c; rdy_cnt = 0; dones++;
            if (dones == 5) start = 1'b0;
         end
         if (ready) rdy_cnt++;
         if (dones < 5) begin
            bcd_in = rand_bcd(1'b0);
            if (ready) begin model(bcd_in, 4, ev, eb); q.push_back(ev); end
         end
      end
      start = 1'b0;
      tests++; if (dones != 5) begin fails++; $display("FAIL b2b_count got=%0d exp=5", dones); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat, ev; bit eb, op, seen;
      logic [BIN_W-1:0] bv; logic e;
      convert(16'h0777, lat, bv, e, op);
      @(negedge clk);
      start = 1'b1; bcd_in = 16'h9999;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      #1;
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", ready); end
      tests++; if (binary_value !== '0 || err !== 1'b0 || done_tick !== 1'b0) begin
         fails++; $display("FAIL midrst_outputs got bv=%0d err=%b tick=%b exp 0/0/0", binary_value, err, done_tick);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin @(negedge clk); if (done_tick) seen = 1'b1; end
      tests++; if (seen) begin fails++; $display("FAIL midrst_no_done got=tick exp=none"); end
      convert(16'h0500, lat, bv, e, op);
      model(16'h0500, 4, ev, eb);
      tests++; if (lat != LAT || bv !== BIN_W'(ev) || e !== 1'b0) begin
         fails++; $display("FAIL midrst_after got lat=%0d val=%0d err=%b exp lat=%0d val=%0d err=0", lat, bv, e, LAT, ev);
      end
   endtask

   task automatic test_small();
      logic [15:0] b;
      int ev, lat; bit eb;
      for (int n = 0; n < 6; n++) begin
         b = (n == 0) ? 16'h0099 : {8'h00, rand_bcd(1'b0) & 16'h00FF};
         model(b, 2, ev, eb);
         @(negedge clk);
         start2 = 1'b1; bcd2 = b[7:0];
         @(posedge clk); #1;
         start2 = 1'b0;
         lat = 0;
         for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done2) begin lat = c; break; end
         end
         tests++;
         if (lat != 8 || bv2 !== 7'(ev) || err2 !== 1'b0) begin
            fails++; $display("FAIL small bcd=%h got lat=%0d val=%0d err=%b exp lat=8 val=%0d err=0", b[7:0], lat, bv2, err2, ev);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_hold();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_small();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
